// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared fold/reduce helpers for the address hash
// hash_fold XORs LSB-first chunks of width asz, then folds into [0, table_sz-1].
package hash_pkg;

  localparam int MAX_KEY = 256;
  localparam int MAX_IDX = 32;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // Bit i of the key lands on index bit (i mod asz); the top chunk is implicitly zero-padded.
  function automatic logic [MAX_IDX-1:0] hash_fold(input logic [MAX_KEY-1:0] key,
                                                   input int in_sz,
                                                   input int asz,
                                                   input int table_sz);
    logic [MAX_IDX-1:0] f;
    logic [4:0]         b;
    f = '0;
    for (int i = 0; i < MAX_KEY; i++) begin
      if (i < in_sz) begin
        b    = 5'(i % asz);
        f[b] = f[b] ^ key[8'(i)];
      end
    end
    // f < 2^asz < 2*table_sz, so a single conditional subtract is enough.
    if (!is_pow2(table_sz) && (f >= MAX_IDX'(table_sz))) begin
      f = f - MAX_IDX'(table_sz);
    end
    return f;
  endfunction

endpackage

// File: rtl/hash_out_reg.sv
// rtl/hash_out_reg.sv - index + valid output register, async active-low reset
// Data loads only on a valid cycle; the valid bit follows its input every edge.
module hash_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  input  logic         d_vld,
  output logic [W-1:0] q,
  output logic         q_vld
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else begin
      q_vld <= d_vld;
      if (d_vld) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/basic_hash_func.sv
// rtl/basic_hash_func.sv - combinational key-to-table-index hash for the FIB
// BASIC_HASH_FUNC_REGOUT_EN builds the registered hf_out_q path; otherwise it is a pass-through.
module basic_hash_func
  import hash_pkg::*;
#(
  parameter int INPUT_SZ = 48,
  parameter int TABLE_SZ = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INPUT_SZ-1:0]           hf_in,
  input  logic                          hf_in_vld,
  output logic [$clog2(TABLE_SZ)-1:0]   hf_out,
  output logic [$clog2(TABLE_SZ)-1:0]   hf_out_q,
  output logic                          hf_out_q_vld
);

  localparam int ASZ = $clog2(TABLE_SZ);

  assign hf_out = ASZ'(hash_fold(MAX_KEY'(hf_in), INPUT_SZ, ASZ, TABLE_SZ));

`ifdef BASIC_HASH_FUNC_REGOUT_EN
  hash_out_reg #(
    .W (ASZ)
  ) u_out_reg (
    .clk   (clk),
    .reset (reset),
    .d     (hf_out),
    .d_vld (hf_in_vld),
    .q     (hf_out_q),
    .q_vld (hf_out_q_vld)
  );
`else
  // No flops in this build; clk and reset stay on the port list for drop-in compatibility.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
  assign hf_out_q         = hf_out;
  assign hf_out_q_vld     = hf_in_vld;
`endif

endmodule

// File: tb/tb_basic_hash_func.sv
// tb/tb_basic_hash_func.sv - self-checking bench for basic_hash_func
// Covers the 48/256, 48/200 and 10/16 configurations, with or without BASIC_HASH_FUNC_REGOUT_EN.
module tb_basic_hash_func;

  logic        clk = 1'b0;
  logic        reset;
  logic        vld;
  logic [47:0] k0, k1;
  logic [9:0]  k2;
  logic [7:0]  o0, q0, o1, q1;
  logic [3:0]  o2, q2;
  logic        qv0, qv1, qv2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  basic_hash_func #(.INPUT_SZ(48), .TABLE_SZ(256)) u0 (
    .clk(clk), .reset(reset), .hf_in(k0), .hf_in_vld(vld),
    .hf_out(o0), .hf_out_q(q0), .hf_out_q_vld(qv0));
  basic_hash_func #(.INPUT_SZ(48), .TABLE_SZ(200)) u1 (
    .clk(clk), .reset(reset), .hf_in(k1), .hf_in_vld(vld),
    .hf_out(o1), .hf_out_q(q1), .hf_out_q_vld(qv1));
  basic_hash_func #(.INPUT_SZ(10), .TABLE_SZ(16)) u2 (
    .clk(clk), .reset(reset), .hf_in(k2), .hf_in_vld(vld),
    .hf_out(o2), .hf_out_q(q2), .hf_out_q_vld(qv2));

  typedef struct {
    int          sel;
    logic [47:0] key;
    int          exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: XOR of asz-bit chunks of the key, then modulo the table size.
  function automatic int ref_hash(input logic [63:0] key, input int in_sz, input int tsz);
    int          asz = $clog2(tsz);
    int          n   = (in_sz + asz - 1) / asz;
    logic [63:0] k;
    int          f   = 0;
    k = key & ((64'd1 << in_sz) - 64'd1);
    for (int c = 0; c < n; c++) begin
      f = f ^ int'((k >> (c * asz)) & ((64'd1 << asz) - 64'd1));
    end
    return f % tsz;
  endfunction

  task automatic drive(input int sel, input logic [47:0] key);
    case (sel)
      0:       k0 = key;
      1:       k1 = key;
      default: k2 = key[9:0];
    endcase
  endtask

  function automatic logic [7:0] got(input int sel);
    case (sel)
      0:       return o0;
      1:       return o1;
      default: return {4'h0, o2};
    endcase
  endfunction

  logic [7:0] eq0;
  logic       ev0;

  initial begin
    vecs[0]  = '{0, 48'h0102_0304_0506, 7};
    vecs[1]  = '{0, 48'h0000_0000_0001, 1};
    vecs[2]  = '{0, 48'hFFFF_FFFF_FFFF, 0};
    vecs[3]  = '{0, 48'h0000_0000_0000, 0};
    vecs[4]  = '{1, 48'h0000_0000_00C8, 0};
    vecs[5]  = '{1, 48'h0000_0000_00FF, 55};
    vecs[6]  = '{1, 48'h0000_0000_00C7, 199};
    vecs[7]  = '{1, 48'h0102_0304_0506, 7};
    vecs[8]  = '{1, 48'h0000_0000_0000, 0};
    vecs[9]  = '{2, 48'h0000_0000_03FF, 3};
    vecs[10] = '{2, 48'h0000_0000_0000, 0};
    vecs[11] = '{2, 48'h0000_0000_02A5, 13};
    vecs[12] = '{2, 48'h0000_0000_03F0, 12};

    reset = 1'b0;
    vld   = 1'b0;
    k0    = '0;
    k1    = '0;
    k2    = '0;
    #1;
    chk("zero_key_u0", o0, 0);
    chk("reset_q0", q0, 0);
    chk("reset_qv0", qv0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].key);
      #1;
      chk($sformatf("vec%0d", i), got(vecs[i].sel), vecs[i].exp);
    end

    eq0 = '0;
    ev0 = 1'b0;
    for (int it = 0; it < 10000; it++) begin
      @(negedge clk);
`ifdef BASIC_HASH_FUNC_REGOUT_EN
      chk("sweep_q0", q0, eq0);
      chk("sweep_qv0", qv0, ev0);
`else
      reset = ($urandom_range(0, 7) != 0);
`endif
      k0  = {$urandom(), $urandom()} >> 16;
      k1  = {$urandom(), $urandom()} >> 16;
      k2  = 10'($urandom());
      vld = $urandom_range(0, 1) == 1;
      #1;
      chk("sweep_u0", o0, ref_hash(64'(k0), 48, 256));
      chk("sweep_u1", o1, ref_hash(64'(k1), 48, 200));
      chk("range_u1", (o1 < 8'd200), 1);
      chk("sweep_u2", o2, ref_hash(64'(k2), 10, 16));
`ifdef BASIC_HASH_FUNC_REGOUT_EN
      if (vld) eq0 = 8'(ref_hash(64'(k0), 48, 256));
      ev0 = vld;
`else
      chk("pass_q0", q0, ref_hash(64'(k0), 48, 256));
      chk("pass_qv0", qv0, vld);
      chk("pass_q1", q1, ref_hash(64'(k1), 48, 200));
      chk("pass_qv1", qv1, vld);
      chk("pass_q2", q2, ref_hash(64'(k2), 10, 16));
      chk("pass_qv2", qv2, vld);
`endif
    end

`ifdef BASIC_HASH_FUNC_REGOUT_EN
    @(negedge clk);
    k0  = 48'h0102_0304_0506;
    vld = 1'b1;
    @(posedge clk);
    #1;
    chk("cap_q0", q0, 8'h07);
    chk("cap_qv0", qv0, 1);
    @(negedge clk);
    k0  = 48'h0000_0000_00FF;
    vld = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_q0", q0, 8'h07);
    chk("hold_qv0", qv0, 0);
    @(negedge clk);
    k0  = 48'h0000_0000_0011;
    vld = 1'b1;
    @(posedge clk);
    #1;
    chk("cap2_q0", q0, 8'h11);
    chk("cap2_qv0", qv0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_q0", q0, 0);
    chk("async_rst_qv0", qv0, 0);
    k0 = 48'h0102_0304_0506;
    #1;
    chk("rst_track_o0", o0, 8'h07);
    @(posedge clk);
    #1;
    chk("rst_held_q0", q0, 0);
    chk("rst_held_qv0", qv0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_q0", q0, 8'h07);
    chk("resume_qv0", qv0, 1);
`else
    @(negedge clk);
    reset = 1'b0;
    vld   = 1'b1;
    k0    = 48'h0102_0304_0506;
    #1;
    chk("rst_pass_q0", q0, 8'h07);
    chk("rst_pass_qv0", qv0, 1);
    reset = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/basic_hash_func.md
# basic_hash_func

Combinational address hash that turns a wide key, typically a 48-bit MAC address, into a table index in `[0, TABLE_SZ-1]`. The FIB lookup state machine drives `ft_addr` from `hf_out` in the same cycle it asserts the table read or write enable. An optional registered copy of the index, with a valid flag, serves pipelined consumers.

## Interface
- `INPUT_SZ`, default 48: key width in bits.
- `TABLE_SZ`, default 256: number of table entries; must be ≥ 2.
- `ASZ`, derived as `$clog2(TABLE_SZ)`: index width; not overridable.

Ports:
- `clk`  input  1  single clock.
- `reset`  input  1  asynchronous, active-low reset (asserted at 0).
- `hf_in`  input  INPUT_SZ  key to hash.
- `hf_in_vld`  input  1  qualifies `hf_in` for the registered path.
- `hf_out`  output  ASZ  combinational hash of `hf_in`.
- `hf_out_q`  output  ASZ  registered hash.
- `hf_out_q_vld`  output  1  qualifies `hf_out_q`.

## Operation
- Fold:
  - Split `hf_in` into `N = ceil(INPUT_SZ/ASZ)` chunks of ASZ bits. Chunk 0 is bits `[ASZ-1:0]`; chunks run LSB-first.
  - Zero-pad the top chunk.
  - `f` = XOR of all chunks.
- Reduce:
  - If `TABLE_SZ` is a power of two, `hf_out = f`.
  - Otherwise `hf_out = (f >= TABLE_SZ) ? f - TABLE_SZ : f`. One subtraction suffices because `f < 2^ASZ < 2*TABLE_SZ`.
- `hf_out` is always in `[0, TABLE_SZ-1]`.
- `hf_out` is purely combinational and depends only on `hf_in`. It is unaffected by `clk`, `reset` and `hf_in_vld`.
- Hashing is deterministic: equal keys always give equal indices. The FIB relies on this for DA lookup and SA write-back.
- A key of all zeros hashes to 0.

## Timing
- `hf_out`: zero-cycle latency, valid in the same cycle as `hf_in`.
- `hf_out_q` / `hf_out_q_vld` with `BASIC_HASH_FUNC_REGOUT_EN` defined:
  - One-cycle latency, captured on each rising `clk`.
  - `hf_out_q_vld` follows `hf_in_vld` one cycle later.
  - `hf_out_q` loads only when `hf_in_vld` is 1; otherwise it holds its value.
- Reset (`reset` = 0):
  - Takes effect immediately, asynchronously.
  - `hf_out_q` = 0 and `hf_out_q_vld` = 0.
  - Registers stay cleared while `reset` is low; capture resumes on the first rising edge after `reset` returns to 1.
- Reset mid-stream drops any pending valid. `hf_out` is unaffected by reset.

## Configuration
- `BASIC_HASH_FUNC_REGOUT_EN` defined: the registered output stage is built as described under Timing.
- Not defined: no flops are instantiated. `hf_out_q = hf_out` and `hf_out_q_vld = hf_in_vld`, both combinational. `clk` and `reset` are unused but remain as ports.

## Structure
- Shared package (`hash_pkg`) holds:
  - the fold/reduce function `hash_fold(key)`, parameterised through ASZ and TABLE_SZ;
  - the power-of-two test `is_pow2(TABLE_SZ)`.
- One natural sub-module: `hash_out_reg`, the ASZ+1-bit async-active-low output register, compiled in under the macro.

## Test plan
- INPUT_SZ 48, TABLE_SZ 256: `hf_in = 48'h0102_0304_0506` → `hf_out = 8'h07` in the same cycle. `hf_in = 48'h1` → `1`. `hf_in = 48'hFFFF_FFFF_FFFF` → `0`.
- INPUT_SZ 48, TABLE_SZ 200 (ASZ 8):
  - `48'hC8` → `0`.
  - `48'hFF` → `55`.
  - `48'hC7` → `199`.
  - Random sweep of 10k keys: every result < 200 and matches the reference fold model.
- INPUT_SZ 10, TABLE_SZ 16 (padding): `hf_in = 10'h3FF` → chunks F, F, 3 → `hf_out = 4'h3`.
- Macro defined:
  - `hf_in_vld` = 1 with key `48'h0102_0304_0506` → `hf_out_q = 07`, `hf_out_q_vld = 1` one edge later.
  - `hf_in_vld` = 0 on the next cycle → `hf_out_q` holds `07` and `hf_out_q_vld` = 0.
- Macro defined: drive `reset` low between edges while `hf_out_q_vld` = 1 → both outputs go to 0 immediately. `hf_out` keeps tracking `hf_in`.
- Macro undefined: `hf_out_q` equals `hf_out` and `hf_out_q_vld` equals `hf_in_vld` every cycle for random stimulus, including during reset.
